// File: rtl/sd_serializer_pkg.sv
// Shared definitions for the signed-digit serializer: digit encodings,
// recoding-mode constants and the controller state type.
package sd_serializer_pkg;

    localparam logic [1:0] SD_ZERO = 2'b00;
    localparam logic [1:0] SD_POS  = 2'b01;
    localparam logic [1:0] SD_NEG  = 2'b10;

    localparam logic MODE_PLAIN = 1'b0;
    localparam logic MODE_BOOTH = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/sd_digit_recoder.sv
// Maps one operand bit (and its lower neighbour) to a signed digit in
// either plain two's-complement weighting or Booth radix-2 recoding.
module sd_digit_recoder
    import sd_serializer_pkg::*;
(
    input  logic       b_i,
    input  logic       b_im1,
    input  logic       is_msb,
    input  logic       mode,
    output logic [1:0] digit
);

    // NOTE: assign every combinational output a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        digit = SD_ZERO;
        if (mode == MODE_BOOTH) begin
            if (b_im1 && !b_i) begin
                digit = SD_POS;
            end else if (!b_im1 && b_i) begin
                digit = SD_NEG;
            end
        end else if (b_i) begin
            // The sign bit carries negative weight in two's complement.
            digit = is_msb ? SD_NEG : SD_POS;
        end
    end

endmodule

// File: rtl/sd_serializer.sv
// Serializes a captured two's-complement word into signed digits, MSB
// first, over a valid/ready handshake; supports plain and Booth recoding.
module sd_serializer
    import sd_serializer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             mode,
    output logic             digit_valid,
    input  logic             digit_ready,
    output logic [1:0]       digit,
    output logic             digit_last,
    output logic             done,
    input  logic             flush
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [WIDTH-1:0] word_q,  word_d;
    logic             mode_q,  mode_d;
    logic             done_q,  done_d;

    logic       b_i;
    logic       b_im1;
    logic       is_msb;
    logic [1:0] rec_digit;

    // The word stays unshifted; the down-counter selects b[i] and b[i-1].
    assign b_i    = word_q[idx_q];
    assign b_im1  = (idx_q == '0) ? 1'b0 : word_q[idx_q - 1'b1];
    assign is_msb = (idx_q == IDX_MSB);

    sd_digit_recoder u_recoder (
        .b_i    (b_i),
        .b_im1  (b_im1),
        .is_msb (is_msb),
        .mode   (mode_q),
        .digit  (rec_digit)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        word_d      = word_q;
        mode_d      = mode_q;
        done_d      = 1'b0;
        load_ready  = 1'b0;
        digit_valid = 1'b0;
        digit       = SD_ZERO;
        digit_last  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid && !flush) begin
                    word_d  = din;
                    mode_d  = mode;
                    idx_d   = IDX_MSB;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                digit_valid = 1'b1;
                digit       = rec_digit;
                digit_last  = (idx_q == '0);
                // Flush wins over a handshake in the same cycle.
                if (flush) begin
                    state_d = ST_IDLE;
                    idx_d   = IDX_MSB;
                end else if (digit_ready) begin
                    if (idx_q == '0) begin
                        state_d = ST_IDLE;
                        idx_d   = IDX_MSB;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_MSB;
            word_q  <= '0;
            mode_q  <= MODE_PLAIN;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_sd_serializer.sv
// Self-checking bench for sd_serializer: a word-level reference model checked
// every cycle, an on-the-fly digit accumulator, and directed corner cases.
module tb_sd_serializer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] din;
    logic         mode;
    logic         digit_valid;
    logic         digit_ready;
    logic [1:0]   digit;
    logic         digit_last;
    logic         done;
    logic         flush;

    int n_tests = 0;
    int n_fail  = 0;

    sd_serializer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .din         (din),
        .mode        (mode),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .digit       (digit),
        .digit_last  (digit_last),
        .done        (done),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Digit value at position i straight from the recoding definitions.
    function automatic int exp_digit(input logic [W-1:0] w, input logic m, input int i);
        int bi;
        int bim1;
        bi   = int'(w[i]);
        bim1 = (i == 0) ? 0 : int'(w[i-1]);
        if (m) return bim1 - bi;
        return (i == W - 1) ? -bi : bi;
    endfunction

    function automatic logic [1:0] enc(input int v);
        if (v == 1)  return 2'b01;
        if (v == -1) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int dec(input logic [1:0] d);
        if (d == 2'b01) return 1;
        if (d == 2'b10) return -1;
        return 0;
    endfunction

    // Word-level model: busy flag, captured word, digits already consumed.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_mode = 1'b0;
    logic [W-1:0] m_word = '0;
    int           m_pos  = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_pos  <= 0;
        end else begin
            m_done <= 1'b0;
            if (flush) begin
                m_busy <= 1'b0;
            end else if (!m_busy) begin
                if (load_valid) begin
                    m_busy <= 1'b1;
                    m_word <= din;
                    m_mode <= mode;
                    m_pos  <= 0;
                end
            end else if (digit_ready) begin
                if (m_pos == W - 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
                m_pos <= m_pos + 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        check("load_ready", load_ready, !m_busy);
        check("digit_valid", digit_valid, m_busy);
        check("done", done, m_done);
        check("digit", digit, m_busy ? enc(exp_digit(m_word, m_mode, W - 1 - m_pos)) : 2'b00);
        check("digit_last", digit_last, m_busy && (m_pos == W - 1));
    end

    // Downstream side: on-the-fly accumulation, stall stability, done count.
    int           got_n    = 0;
    logic [2*W-1:0] got_bits = '0;
    longint       acc      = 0;
    int           last_at  = -1;
    int           done_cnt = 0;
    longint       values[$];
    logic         prev_stall = 1'b0;
    logic [1:0]   prev_digit = 2'b00;

    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
        check("digit_code", digit == 2'b11, 0);
        if (prev_stall && digit_valid) check("stall_hold", digit, prev_digit);
        prev_stall = digit_valid && !digit_ready && !flush;
        prev_digit = digit;
        if (digit_valid && digit_ready && !flush && reset) begin
            got_bits = {got_bits[2*W-3:0], digit};
            got_n++;
            acc = acc * 2 + longint'(dec(digit));
            if (digit_last) begin
                last_at = got_n;
                values.push_back(acc);
                acc = 0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_collect();
        got_n    = 0;
        got_bits = '0;
        acc      = 0;
        last_at  = -1;
        values.delete();
    endtask

    function automatic logic rand_ready(input int stall_pct);
        return ($urandom_range(99) >= stall_pct);
    endfunction

    function automatic longint pop_value();
        if (values.size() == 0) return -longint'(1) <<< 40;
        return values.pop_front();
    endfunction

    // Offers one word, drains it, and reports the number of done pulses seen.
    task automatic send_word(input logic [W-1:0] w, input logic m, input int stall_pct,
                             output int ndone);
        int budget;
        clear_collect();
        ndone  = 0;
        budget = 0;
        while (!load_ready && budget < 50) begin
            step();
            budget++;
        end
        load_valid  = 1'b1;
        din         = w;
        mode        = m;
        digit_ready = rand_ready(stall_pct);
        step();
        budget = 0;
        while (got_n < W && budget < 40 * W) begin
            din         = W'($urandom);
            mode        = 1'($urandom_range(1));
            load_valid  = (got_n < W - 2) ? 1'($urandom_range(1)) : 1'b0;
            digit_ready = rand_ready(stall_pct);
            step();
            if (done) ndone++;
            budget++;
        end
        load_valid = 1'b0;
        check("word_finished_in_budget", budget < 40 * W, 1);
    endtask

    initial begin
        int nd;
        int budget;
        int d0;
        logic [W-1:0] w;
        logic         m;

        reset       = 1'b0;
        load_valid  = 1'b0;
        din         = '0;
        mode        = 1'b0;
        digit_ready = 1'b0;
        flush       = 1'b0;

        #12;
        check("rst_load_ready", load_ready, 1);
        check("rst_digit_valid", digit_valid, 0);
        check("rst_digit", digit, 0);
        check("rst_digit_last", digit_last, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();

        send_word(16'h8001, 1'b0, 0, nd);
        check("p8001_digits", got_bits, 32'h8000_0001);
        check("p8001_last_at", last_at, 16);
        check("p8001_done_cnt", nd, 1);
        check("p8001_done_now", done, 1);
        check("p8001_valid_low", digit_valid, 0);
        check("p8001_value", pop_value(), -32767);

        send_word(16'h0007, 1'b1, 0, nd);
        check("b0007_digits", got_bits, 32'h0000_0042);
        check("b0007_value", pop_value(), 7);

        send_word(16'hFFFF, 1'b1, 0, nd);
        check("bFFFF_digits", got_bits, 32'h0000_0002);
        check("bFFFF_value", pop_value(), -1);

        send_word(16'hFFFF, 1'b0, 0, nd);
        check("pFFFF_digits", got_bits, 32'h9555_5555);
        check("pFFFF_value", pop_value(), -1);

        send_word(16'h5A5A, 1'b0, 50, nd);
        check("stall_plain_count", got_n, 16);
        check("stall_plain_done", nd, 1);
        check("stall_plain_value", pop_value(), 23130);
        send_word(16'h5A5A, 1'b1, 50, nd);
        check("stall_booth_count", got_n, 16);
        check("stall_booth_done", nd, 1);
        check("stall_booth_value", pop_value(), 23130);
        step();

        // Load with flush in IDLE must be refused.
        flush      = 1'b1;
        load_valid = 1'b1;
        din        = 16'h1234;
        step();
        flush      = 1'b0;
        load_valid = 1'b0;
        check("idle_flush_no_load", digit_valid, 0);
        step();

        // Flush part-way through a word, overriding a handshake and a load.
        clear_collect();
        d0          = done_cnt;
        load_valid  = 1'b1;
        din         = 16'h1234;
        mode        = 1'b1;
        digit_ready = 1'b1;
        step();
        load_valid = 1'b0;
        budget     = 0;
        while (got_n < 7 && budget < 100) begin
            step();
            budget++;
        end
        flush      = 1'b1;
        load_valid = 1'b1;
        step();
        flush      = 1'b0;
        load_valid = 1'b0;
        check("flush_valid_low", digit_valid, 0);
        check("flush_load_ready", load_ready, 1);
        check("flush_no_done", done, 0);
        check("flush_digits_taken", got_n, 7);
        repeat (3) step();
        check("flush_no_late_done", done_cnt, d0);

        // Asynchronous reset in the middle of the following word.
        clear_collect();
        load_valid = 1'b1;
        din        = 16'hBEEF;
        mode       = 1'b0;
        step();
        load_valid = 1'b0;
        budget     = 0;
        while (got_n < 3 && budget < 100) begin
            step();
            budget++;
        end
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid_low", digit_valid, 0);
        check("arst_digit_zero", digit, 0);
        check("arst_last_low", digit_last, 0);
        check("arst_done_low", done, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        check("arst_release_load_ready", load_ready, 1);
        check("arst_release_valid", digit_valid, 0);
        repeat (W + 2) step();
        check("arst_no_more_digits", got_n, 3);
        check("arst_no_done", done_cnt, d0);

        // Loopback of random words in both modes.
        for (int k = 0; k < 1000; k++) begin
            w = W'($urandom);
            m = 1'($urandom_range(1));
            send_word(w, m, (k % 4 == 0) ? 40 : 0, nd);
            check("loop_value", pop_value(), longint'($signed(w)));
            check("loop_done_once", nd, 1);
        end
        digit_ready = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
